// File: rtl/tempsens_scan_mc_if.sv
// Control and readout bundle for tempsens_scan_mc.
// The master drives the i_* signals and the slave (the sequencer) drives the o_* signals.
interface tempsens_scan_mc_if #(
    parameter int NCH    = 4,
    parameter int GATE_W = 12
);
    localparam int SEL_W = $clog2(NCH);

    logic              i_start;
    logic              i_continuous;
    logic [GATE_W-1:0] i_gate_len;
    logic [NCH-1:0]    i_ch_mask;
    logic [SEL_W-1:0]  i_rd_sel;
    logic              i_snap;
    logic [1:0]        i_byte_sel;
    logic [7:0]        o_data;
    logic              o_busy;
    logic              o_done;
    logic [NCH-1:0]    o_valid;
    logic [NCH-1:0]    o_ovf;

    modport master (
        output i_start, i_continuous, i_gate_len, i_ch_mask,
        output i_rd_sel, i_snap, i_byte_sel,
        input  o_data, o_busy, o_done, o_valid, o_ovf
    );

    modport slave (
        input  i_start, i_continuous, i_gate_len, i_ch_mask,
        input  i_rd_sel, i_snap, i_byte_sel,
        output o_data, o_busy, o_done, o_valid, o_ovf
    );
endinterface

// File: rtl/tempsens_scan_mc.sv
// Multi-channel ring-oscillator edge-count sequencer with a tear-free byte-wise snapshot readout.
// Optional macro TEMPSENS_AVG_EN averages 2^AVG_LOG2 gate windows per channel.
module tempsens_scan_mc #(
    parameter int NCH      = 4,
    parameter int CNT_W    = 20,
    parameter int GATE_W   = 12,
    parameter int AVG_LOG2 = 2
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic [NCH-1:0]       i_osc,
    tempsens_scan_mc_if.slave    bus
);
    localparam int CH_W = $clog2(NCH);

`ifdef TEMPSENS_AVG_EN
    localparam int WIN_LOG2 = AVG_LOG2;
`else
    // Without averaging there is exactly one window, so the accumulator collapses to the counter.
    localparam int WIN_LOG2 = 0 * AVG_LOG2;
`endif

    localparam int ACC_W = CNT_W + WIN_LOG2;

    typedef enum logic [2:0] {
        IDLE,
        SETTLE,
        COUNT,
        STORE,
        NEXT
    } state_t;

    state_t            state;
    state_t            state_nxt;

    logic [NCH-1:0]    mask_q;
    logic [GATE_W-1:0] gate_q;
    logic [GATE_W-1:0] timer;
    logic [GATE_W-1:0] gate_in;
    logic [CH_W-1:0]   ch_q;
    logic [CH_W-1:0]   ch_first;
    logic [CH_W-1:0]   ch_higher;
    logic [NCH-1:0]    higher_mask;
    logic              has_higher;
    logic              settle_cnt;
    logic              hist;
    logic              osc_cur;
    logic              rise;
    logic              sat;
    logic              gate_last;
    logic              count_done;
    logic              latch;
    logic              done;
    logic [ACC_W-1:0]  cnt;
    logic [CNT_W-1:0]  result [NCH];
    logic [NCH-1:0]    valid_q;
    logic [NCH-1:0]    ovf_q;
    logic [31:0]       snap_q;
    logic [7:0]        data;

`ifdef TEMPSENS_AVG_EN
    logic [WIN_LOG2-1:0] win;
    logic                win_last;
`endif

    function automatic logic [CH_W-1:0] lowest_set(input logic [NCH-1:0] m);
        lowest_set = '0;
        for (int i = NCH - 1; i >= 0; i--) begin
            if (m[i]) begin
                lowest_set = CH_W'(i);
            end
        end
    endfunction

    // Remaining channels of the latched mask strictly above the current pointer.
    always_comb begin
        higher_mask = '0;
        for (int i = 0; i < NCH; i++) begin
            higher_mask[i] = mask_q[i] && (i > int'(ch_q));
        end
    end

    assign has_higher = |higher_mask;
    assign ch_higher  = lowest_set(higher_mask);
    assign ch_first   = lowest_set(bus.i_ch_mask);
    assign gate_in    = (bus.i_gate_len == '0) ? GATE_W'(1) : bus.i_gate_len;
    assign osc_cur    = i_osc[ch_q];
    assign rise       = osc_cur & ~hist;
    assign gate_last  = (timer == gate_q - GATE_W'(1));

`ifdef TEMPSENS_AVG_EN
    assign win_last   = &win;
    assign count_done = gate_last && win_last;
`else
    assign count_done = gate_last;
`endif

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        latch     = 1'b0;
        done      = 1'b0;
        case (state)
            IDLE: begin
                if (bus.i_start && (|bus.i_ch_mask)) begin
                    latch     = 1'b1;
                    state_nxt = SETTLE;
                end
            end
            SETTLE: begin
                if (settle_cnt) begin
                    state_nxt = COUNT;
                end
            end
            COUNT: begin
                if (count_done) begin
                    state_nxt = STORE;
                end
            end
            STORE: begin
                state_nxt = NEXT;
            end
            NEXT: begin
                if (has_higher) begin
                    state_nxt = SETTLE;
                end else begin
                    done = 1'b1;
                    if (bus.i_continuous && (|bus.i_ch_mask)) begin
                        latch     = 1'b1;
                        state_nxt = SETTLE;
                    end else begin
                        state_nxt = IDLE;
                    end
                end
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    // Measurement datapath; the snapshot load sees the pre-store result on a same-cycle collision.
    always_ff @(posedge clk) begin
        if (reset) begin
            mask_q     <= '0;
            gate_q     <= GATE_W'(1);
            ch_q       <= '0;
            timer      <= '0;
            settle_cnt <= 1'b0;
            hist       <= 1'b0;
            cnt        <= '0;
            sat        <= 1'b0;
            valid_q    <= '0;
            ovf_q      <= '0;
            snap_q     <= '0;
            for (int i = 0; i < NCH; i++) begin
                result[i] <= '0;
            end
`ifdef TEMPSENS_AVG_EN
            win        <= '0;
`endif
        end else begin
            settle_cnt <= 1'b0;
            if (latch) begin
                mask_q <= bus.i_ch_mask;
                gate_q <= gate_in;
                ch_q   <= ch_first;
            end
            case (state)
                SETTLE: begin
                    settle_cnt <= ~settle_cnt;
                    hist       <= osc_cur;
                    cnt        <= '0;
                    sat        <= 1'b0;
                    timer      <= '0;
`ifdef TEMPSENS_AVG_EN
                    win        <= '0;
`endif
                end
                COUNT: begin
                    hist  <= osc_cur;
                    timer <= gate_last ? '0 : timer + GATE_W'(1);
`ifdef TEMPSENS_AVG_EN
                    if (gate_last) begin
                        win <= win + WIN_LOG2'(1);
                    end
`endif
                    // Saturating at full scale keeps the averaged result pinned at all-ones with ovf set.
                    if (rise) begin
                        if (&cnt) begin
                            sat <= 1'b1;
                        end else begin
                            cnt <= cnt + ACC_W'(1);
                        end
                    end
                end
                STORE: begin
                    result[ch_q]  <= CNT_W'(cnt >> WIN_LOG2);
                    valid_q[ch_q] <= 1'b1;
                    ovf_q[ch_q]   <= sat;
                end
                NEXT: begin
                    if (has_higher) begin
                        ch_q <= ch_higher;
                    end
                end
                default: begin
                end
            endcase
            if (bus.i_snap) begin
                snap_q <= (int'(bus.i_rd_sel) < NCH) ? 32'(result[bus.i_rd_sel]) : 32'd0;
            end
        end
    end

    // Byte 3 carries a signature when the result never reaches it.
    always_comb begin
        data = 8'h00;
        case (bus.i_byte_sel)
            2'd0:    data = snap_q[7:0];
            2'd1:    data = snap_q[15:8];
            2'd2:    data = snap_q[23:16];
            default: data = (CNT_W <= 24) ? 8'h69 : snap_q[31:24];
        endcase
    end

    assign bus.o_data  = data;
    assign bus.o_busy  = (state != IDLE);
    assign bus.o_done  = done;
    assign bus.o_valid = valid_q;
    assign bus.o_ovf   = ovf_q;
endmodule
